cache_nway: RTL

- Parametrised N-way set-associative, write-back, write-allocate data/instruction cache.
- Sits between a pipeline stage (core side: addr/read_write/master_enable, hit used as stall) and the memory arbiter (separate read/write req/ack channels).
- Generalises the 4-way cache:
  - WAYS is a parameter.
  - Per-index tree pseudo-LRU.
  - Explicit miss FSM with a latched miss address.
  - Line-aligned fills.
  - Full-cache flush (write back all dirty lines, then invalidate).

---
 rtl/cache_nway_pkg.sv | 24 ++
 rtl/cache_nway_plru.sv | 42 ++++
 rtl/cache_nway.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/cache_nway_pkg.sv
// Shared definitions for the N-way cache slice.
//   state_t      : miss/flush controller states (3-bit encoding)
//   RW_READ/WRITE: read_write port encoding
//   offset_bits  : byte-offset width of a line given its bit width
package cache_nway_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    EVICT      = 3'd1,
    FILL       = 3'd2,
    FLUSH_SCAN = 3'd3,
    FLUSH_WB   = 3'd4
  } state_t;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // Address layout is tag | index | offset; offset width follows from the
  // line width in bytes.
  function automatic int unsigned offset_bits(input int unsigned width);
    return $clog2(width) - 3;
  endfunction

endpackage

// File: rtl/cache_nway_plru.sv
// Combinational tree pseudo-LRU for one cache index.
//   tree       : current node bits (heap order, node 0 = root, 0 = victim left)
//   access_way : way being touched
//   access_en  : apply the access to produce tree_next
//   tree_next  : tree with the accessed path pointing away from access_way
//   victim     : way selected by following the node bits from the root
module plru_tree #(
  parameter int unsigned WAYS = 4
) (
  input  logic [WAYS-2:0]         tree,
  input  logic [$clog2(WAYS)-1:0] access_way,
  input  logic                    access_en,
  output logic [WAYS-2:0]         tree_next,
  output logic [$clog2(WAYS)-1:0] victim
);

  localparam int unsigned LW = $clog2(WAYS);

  always_comb begin
    int unsigned node;
    victim = '0;
    node   = 0;
    for (int unsigned l = 0; l < LW; l++) begin
      victim[LW-1-l] = tree[node];
      node = 32'd2 * node + (tree[node] ? 32'd2 : 32'd1);
    end
  end

  always_comb begin
    int unsigned node;
    tree_next = tree;
    node      = 0;
    if (access_en) begin
      for (int unsigned l = 0; l < LW; l++) begin
        // Going left means the victim should now lie right, and vice versa.
        tree_next[node] = ~access_way[LW-1-l];
        node = 32'd2 * node + (access_way[LW-1-l] ? 32'd2 : 32'd1);
      end
    end
  end

endmodule

// File: rtl/cache_nway.sv
// N-way set-associative, write-back, write-allocate cache with tree PLRU,
// a latched-address miss FSM and a full flush sweep.
//   clk/reset            : clock, asynchronous active-high reset
//   addr/read_write/
//   master_enable        : core access (read_write 1 = read)
//   byte_enable/data_in  : byte-lane write mask and data
//   data_out             : registered line data of the last hit
//   hit                  : combinational, IDLE and tag match (core stall)
//   flush/flush_busy     : start full write-back+invalidate / sweep active
//   mem_write_*          : write-back channel (req held until ack)
//   mem_read_*           : line fill channel (req held until ack)
module cache_nway
  import cache_nway_pkg::*;
#(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WAYS  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        addr,
  input  logic               read_write,
  input  logic               master_enable,
  input  logic [WIDTH/8-1:0] byte_enable,
  input  logic [WIDTH-1:0]   data_in,
  output logic [WIDTH-1:0]   data_out,
  output logic               hit,
  input  logic               flush,
  output logic               flush_busy,
  output logic               mem_write_req,
  output logic [31:0]        mem_write_addr,
  output logic [WIDTH-1:0]   mem_write_data,
  input  logic               mem_write_ack,
  output logic               mem_read_req,
  output logic [31:0]        mem_read_addr,
  input  logic [WIDTH-1:0]   mem_read_data,
  input  logic               mem_read_ack
);

  localparam int unsigned WB    = offset_bits(WIDTH);
  localparam int unsigned DB    = $clog2(DEPTH);
  localparam int unsigned BYTES = 2 ** WB;
  localparam int unsigned TAGW  = 32 - WB - DB;
  localparam int unsigned LW    = $clog2(WAYS);

  state_t state, state_next;

  logic [WIDTH-1:0] line_mem [DEPTH][WAYS];
  logic [TAGW-1:0]  tag_mem  [DEPTH][WAYS];
  logic [WAYS-1:0]  valid    [DEPTH];
  logic [WAYS-1:0]  dirty    [DEPTH];
  logic [WAYS-2:0]  plru     [DEPTH];

  logic [31-WB:0]   miss_line;
  logic [LW-1:0]    victim_way;
  logic [DB+LW-1:0] scan_ptr;
  logic             scan_last;

  logic [DB-1:0]    a_idx, m_idx, s_idx;
  logic [TAGW-1:0]  a_tag, m_tag;
  logic [LW-1:0]    s_way;
  logic [WAYS-1:0]  hit_vec;
  logic [LW-1:0]    hit_way, inv_way, plru_victim, victim;
  logic             inv_found, victim_dirty;
  logic [WAYS-2:0]  plru_next;
  logic [WIDTH-1:0] mask, merged;
  logic             fill_done, wb_ack, scan_dirty, scan_end;
  logic             unused_bits;

  assign a_idx = addr[WB+DB-1:WB];
  assign a_tag = addr[31:WB+DB];
  assign m_idx = miss_line[DB-1:0];
  assign m_tag = miss_line[31-WB:DB];
  assign s_idx = scan_ptr[DB+LW-1:LW];
  assign s_way = scan_ptr[LW-1:0];
  assign unused_bits = ^addr[WB-1:0];

  // Descending scans so the lowest matching way wins.
  always_comb begin
    hit_vec   = '0;
    hit_way   = '0;
    inv_way   = '0;
    inv_found = 1'b0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      hit_vec[w] = valid[a_idx][w] && (tag_mem[a_idx][w] == a_tag);
    end
    for (int unsigned w = WAYS; w > 0; w--) begin
      if (hit_vec[w-1]) hit_way = LW'(w - 1);
      if (!valid[a_idx][w-1]) begin
        inv_way   = LW'(w - 1);
        inv_found = 1'b1;
      end
    end
  end

  plru_tree #(.WAYS(WAYS)) u_plru (
    .tree       (plru[a_idx]),
    .access_way (hit_way),
    .access_en  (hit),
    .tree_next  (plru_next),
    .victim     (plru_victim)
  );

  always_comb begin
    mask = '0;
    for (int unsigned b = 0; b < BYTES; b++) begin
      mask[b*8 +: 8] = {8{byte_enable[b]}};
    end
  end

  assign hit          = (state == IDLE) && (|hit_vec);
  assign victim       = inv_found ? inv_way : plru_victim;
  assign victim_dirty = valid[a_idx][victim] && dirty[a_idx][victim];
  assign merged       = (line_mem[a_idx][hit_way] & ~mask) | (data_in & mask);
  assign fill_done    = (state == FILL) && mem_read_req && mem_read_ack;
  assign wb_ack       = mem_write_req && mem_write_ack;
  assign scan_dirty   = valid[s_idx][s_way] && dirty[s_idx][s_way];
  assign scan_end     = &scan_ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:       if (flush) state_next = FLUSH_SCAN;
                  else if (master_enable && !hit) state_next = victim_dirty ? EVICT : FILL;
      EVICT:      if (wb_ack) state_next = FILL;
      FILL:       if (fill_done) state_next = IDLE;
      FLUSH_SCAN: if (scan_dirty) state_next = FLUSH_WB;
                  else if (scan_end) state_next = IDLE;
      FLUSH_WB:   if (wb_ack) state_next = scan_last ? IDLE : FLUSH_SCAN;
      default:    state_next = IDLE;
    endcase
  end

  // Tag and line storage are intentionally not reset; writes need a hit
  // (valid set) or FILL, neither of which can occur while reset is held.
  always_ff @(posedge clk) begin
    if (state == IDLE && !flush && master_enable && hit && read_write == RW_WRITE)
      line_mem[a_idx][hit_way] <= merged;
    if (fill_done) begin
      line_mem[m_idx][victim_way] <= mem_read_data;
      tag_mem[m_idx][victim_way]  <= m_tag;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        valid[i] <= '0;
        dirty[i] <= '0;
        plru[i]  <= '0;
      end
      data_out       <= '0;
      flush_busy     <= 1'b0;
      mem_write_req  <= 1'b0;
      mem_write_addr <= '0;
      mem_write_data <= '0;
      mem_read_req   <= 1'b0;
      mem_read_addr  <= '0;
      miss_line      <= '0;
      victim_way     <= '0;
      scan_ptr       <= '0;
      scan_last      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (flush) begin
            flush_busy <= 1'b1;
            scan_ptr   <= '0;
            scan_last  <= 1'b0;
          end else if (master_enable && hit) begin
            data_out     <= merged;
            plru[a_idx]  <= plru_next;
            if (read_write == RW_WRITE) dirty[a_idx][hit_way] <= 1'b1;
            else                        data_out <= line_mem[a_idx][hit_way];
          end else if (master_enable) begin
            miss_line  <= addr[31:WB];
            victim_way <= victim;
            if (victim_dirty) begin
              mem_write_req        <= 1'b1;
              mem_write_addr       <= {tag_mem[a_idx][victim], a_idx, {WB{1'b0}}};
              mem_write_data       <= line_mem[a_idx][victim];
              valid[a_idx][victim] <= 1'b0;
            end else begin
              mem_read_req  <= 1'b1;
              mem_read_addr <= {addr[31:WB], {WB{1'b0}}};
            end
          end
        end
        EVICT: begin
          if (wb_ack) begin
            mem_write_req <= 1'b0;
            mem_read_req  <= 1'b1;
            mem_read_addr <= {miss_line, {WB{1'b0}}};
          end
        end
        FILL: begin
          if (fill_done) begin
            valid[m_idx][victim_way] <= 1'b1;
            dirty[m_idx][victim_way] <= 1'b0;
            mem_read_req             <= 1'b0;
          end
        end
        FLUSH_SCAN: begin
          valid[s_idx][s_way] <= 1'b0;
          dirty[s_idx][s_way] <= 1'b0;
          plru[s_idx]         <= '0;
          scan_ptr            <= scan_ptr + 1'b1;
          if (scan_dirty) begin
            mem_write_req  <= 1'b1;
            mem_write_addr <= {tag_mem[s_idx][s_way], s_idx, {WB{1'b0}}};
            mem_write_data <= line_mem[s_idx][s_way];
            scan_last      <= scan_end;
          end else if (scan_end) begin
            flush_busy <= 1'b0;
          end
        end
        FLUSH_WB: begin
          if (wb_ack) begin
            mem_write_req <= 1'b0;
            if (scan_last) flush_busy <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
